// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and defaults.
//   fetch_entry_t    : {pc, inst} pair at the default 32/32 widths
//   RESET_PC_DEFAULT : PC loaded on reset
//   PC_STEP_DEFAULT  : sequential PC increment
//   INST_NOP         : canonical no-op encoding (andi r0,r0,0)
package fetch_pkg;
  localparam int          FETCH_ADDR_W     = 32;
  localparam int          FETCH_INST_W     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;
  localparam int          PC_STEP_DEFAULT  = 4;
  localparam logic [31:0] INST_NOP         = 32'h0340_0000;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch queue bus: instruction-memory request/response plus the
// decode-side valid/ready output.
//   master : the fetch queue (drives imem request and decode output)
//   slave  : memory + decode side
interface if_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic                     imem_req;
  logic [ADDR_W-1:0]        imem_addr;
  logic                     imem_rvalid;
  logic [INST_W-1:0]        imem_rdata;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDR_W-1:0]        out_pc;
  logic [INST_W-1:0]        out_inst;
  logic [ADDR_W+INST_W-1:0] out_bus;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    output out_valid, out_pc, out_inst, out_bus,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    input  out_valid, out_pc, out_inst, out_bus,
    output out_ready
  );
endinterface

// File: rtl/sync_fifo_flush.sv
// Synchronous FIFO with single-cycle flush.
//   clk, reset   : clock, synchronous active-high reset
//   flush        : empties the FIFO at the edge (wins over push/pop)
//   push/push_data, pop : enqueue / dequeue at the edge
//   head_data    : entry at the read pointer (undefined when empty)
//   count, full, empty : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo_flush #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; head is only observed when count != 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // The issue credit upstream guarantees a slot for every push.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push) assert (!full);
  end
endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage with decoupling queue.
//   clk, reset      : clock, synchronous active-high reset
//   redirect_valid  : flush buffer + in-flight fetch, restart at redirect_pc
//   redirect_pc     : new PC (low two bits dropped)
//   bus (master)    : imem_req/imem_addr out, imem_rvalid/imem_rdata in
//                     (fixed 1-cycle latency), out_valid/out_ready
//                     handshake with out_pc/out_inst/out_bus to decode
//   occupancy       : current queue count
// A request is issued only when the queue can hold it even if decode
// never pops, so responses never need to be stalled or dropped for space.
module if_fetch_queue
  import fetch_pkg::*;
#(
  parameter  int                ADDR_W   = 32,
  parameter  int                INST_W   = 32,
  parameter  int                DEPTH    = 4,
  parameter  logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter  int                PC_STEP  = PC_STEP_DEFAULT,
  localparam int                CW       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  if_fetch_queue_if.master  bus,
  output logic [CW-1:0]     occupancy
);
  // Same layout as fetch_entry_t, but sized by this instance's widths.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  localparam int PW = CW + 1;

  logic [ADDR_W-1:0] pc, req_pc;
  logic              inflight;
  logic              push, pop, full, empty;
  logic [CW-1:0]     count;
  logic [PW-1:0]     pending;
  entry_t            head, push_e;
  logic              unused;

  // Dequeue in the same cycle is not credited: keeps the issue path
  // independent of out_ready.
  assign pending      = PW'(count) + PW'(inflight);
  assign bus.imem_req  = !reset && !redirect_valid && (pending < PW'(DEPTH));
  assign bus.imem_addr = pc;

  assign push   = bus.imem_rvalid && inflight && !redirect_valid;
  assign push_e = '{pc: req_pc, inst: bus.imem_rdata};

  assign bus.out_valid = !empty && !reset;
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_pc    = bus.out_valid ? head.pc   : '0;
  assign bus.out_inst  = bus.out_valid ? head.inst : '0;
  assign bus.out_bus   = {bus.out_pc, bus.out_inst};
  assign occupancy     = count;

  assign unused = ^{redirect_pc[1:0], full};

  sync_fifo_flush #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + INST_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_e),
    .pop       (pop),
    .head_data (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // imem_req is already low under reset/redirect, so inflight clears then.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= bus.imem_req;
      if (redirect_valid) begin
        pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      end else if (bus.imem_req) begin
        pc     <= pc + ADDR_W'(PC_STEP);
        req_pc <= pc;
      end
    end
  end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised fetch stage: owns the PC, issues sequential requests to a fixed-latency (1-cycle) instruction memory, and buffers returned {pc, inst} pairs in a DEPTH-entry FIFO.
- Presents buffered pairs to the decode stage over a valid/ready handshake.
- Accepts a redirect from branch/exception logic that flushes the buffer and in-flight fetches.
- Sits between the instruction memory and decode; it decouples fetch from decode backpressure, which the single-register fetch stage cannot do.

Parameters:
- ADDR_W, 32, PC/address width.
- INST_W, 32, instruction width.
- DEPTH, 4, FIFO entries; power of two, at least 2; at least 3 is needed for one instruction per cycle.
- RESET_PC, 32'h1C000000, PC loaded on reset.
- PC_STEP, 4, sequential PC increment.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- redirect_valid  in  1  branch/flush request this cycle
- redirect_pc  in  ADDR_W  new fetch PC; bits [1:0] are ignored (forced to 0)
- imem_req  out  1  fetch request this cycle
- imem_addr  out  ADDR_W  fetch address (the current PC)
- imem_rvalid  in  1  response valid; always exactly 1 cycle after imem_req
- imem_rdata  in  INST_W  fetched instruction
- out_valid  out  1  head entry is valid
- out_ready  in  1  decode accepts the head entry
- out_pc  out  ADDR_W  head PC
- out_inst  out  INST_W  head instruction
- out_bus  out  ADDR_W+INST_W  {out_pc, out_inst}, PC in the upper bits
- occupancy  out  $clog2(DEPTH)+1  current FIFO count (debug/perf)

Behaviour:
- Reset (synchronous, priority over everything):
  - pc = RESET_PC, FIFO empty, occupancy = 0, inflight = 0.
  - out_valid = 0; out_pc, out_inst, out_bus = 0.
  - imem_req = 0 during the reset cycle.
  - Reset mid-operation discards all entries; a response arriving in the cycle after reset is dropped because inflight = 0.
- inflight register: 1 when imem_req was asserted in the previous cycle.
- Issue rule (combinational):
  - imem_req = !reset && !redirect_valid && (occupancy + inflight < DEPTH).
  - Same-cycle dequeue is deliberately not credited.
  - imem_addr = pc.
  - When imem_req = 1, pc <= pc + PC_STEP at the clock edge; the addition wraps modulo 2^ADDR_W.
- Response:
  - If imem_rvalid && inflight && !redirect_valid, push {pc_of_request, imem_rdata}.
  - pc_of_request is held in a register captured at issue.
  - imem_rvalid without inflight is ignored.
- Latency: request in cycle N, push at the end of N+1, out_valid = 1 in N+2. There is no bypass.
- Pop: when out_valid && out_ready, at the clock edge. out_pc/out_inst are driven from the head entry and stay stable while out_valid && !out_ready.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- Pointers: $clog2(DEPTH)-bit read/write pointers wrap naturally. Full is occupancy == DEPTH; empty is occupancy == 0.
- Push when full cannot happen by construction; assert this in simulation.
- Redirect (cycle R):
  - imem_req = 0 in R.
  - Any response in R is dropped.
  - FIFO is cleared and inflight <= 0 at the edge.
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - out_valid = 0 from R+1.
  - First new request is issued in R+1; its instruction is visible at R+3.
- Redirect with a pop in the same cycle: the redirect wins. The pop handshake in R still counts as consumed by decode; the redirecting stage is responsible for ignoring it.
- Redirect held for consecutive cycles: each cycle re-flushes; the last redirect_pc wins.
- Steady state (DEPTH ≥ 3, out_ready = 1): one out_valid per cycle with consecutive PCs.

Decomposition:
- Shared package `fetch_pkg`:
  - fetch_entry_t struct {pc, inst}.
  - RESET_PC_DEFAULT, PC_STEP_DEFAULT, INST_NOP.
- One sub-module, `sync_fifo_flush`: parametrised DEPTH/WIDTH FIFO with push, pop, flush, count, full, empty, and head data.
- The top module holds the PC, the inflight/issue logic, and the redirect logic.

Test Plan:
- Reset then out_ready = 1, memory returns inst = addr ^ 32'hFFFF_FFFF:
  - imem_addr 1C000000, 1C000004, 1C000008 on consecutive cycles.
  - out_valid first rises 2 cycles after the first request.
  - out_pc increments by 4 every cycle with the matching out_inst.
- out_ready = 0 for 10 cycles with DEPTH = 4:
  - occupancy saturates at 4 and imem_req stays 0.
  - Head stays out_pc = 1C000000.
  - Releasing out_ready drains in order with no loss or duplicate.
- Redirect at cycle R to 0x1C000103 while an entry is in flight and 2 are buffered:
  - In-flight response dropped; out_valid = 0 at R+1 and R+2.
  - imem_addr = 1C000100 at R+1; out_pc = 1C000100 at R+3.
- Redirect and out_ready in the same cycle with the FIFO full:
  - FIFO empty afterwards; no stale PC is ever presented.
  - occupancy = 0 at R+1.
- Wrap-around:
  - PC wraps: redirect to FFFFFFF8 gives imem_addr FFFFFFF8, FFFFFFFC, 00000000.
  - FIFO pointers wrap: random out_ready over 1000 cycles, scoreboard order matches issue order.
- Reset asserted while 3 entries are buffered and 1 is in flight:
  - Next cycle out_valid = 0, occupancy = 0, the late imem_rvalid is ignored.
  - First post-reset imem_addr = 1C000000.
